// File: rtl/stage_collision_if.sv
// Geometry ROM bus between the collision scanner (master) and the stage ROM (slave).
// The ROM answers combinationally, so box data for the presented address is sampled on the next edge.
interface stage_collision_if;
   logic [7:0]  box_addr;
   logic        box_rd;
   logic [63:0] box_data;
   logic        box_is_platform;

   modport master (
      output box_addr,
      output box_rd,
      input  box_data,
      input  box_is_platform
   );

   modport slave (
      input  box_addr,
      input  box_rd,
      output box_data,
      output box_is_platform
   );
endinterface

// File: rtl/stage_collision.sv
// Per-frame player/stage collision scanner: walks the geometry ROM one box per cycle and
// publishes a held 5-bit contact vector {platform_Down, Left, Right, Down, Up} for the physics block.
module stage_collision #(
   parameter int NUM_BOXES = 4,
   parameter int PLAYER_W  = 16,
   parameter int PLAYER_H  = 16
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic [31:0]        i_position,
   input  logic [31:0]        i_controller_in,
   stage_collision_if.master  bus,
   output logic [31:0]        o_wall,
   output logic               o_busy,
   output logic               o_done
);

   localparam logic signed [17:0] LP_W    = 18'(PLAYER_W);
   localparam logic signed [17:0] LP_H    = 18'(PLAYER_H);
   localparam logic [7:0]         LP_LAST = 8'(NUM_BOXES - 1);

   typedef enum logic {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;

   state_t      r_state, w_next_state;
   logic [7:0]  r_addr;
   logic        r_rd, r_done, r_drop;
   logic [4:0]  r_wall, r_acc, w_cur;
   logic [15:0] r_px, r_py;
   logic        w_last, w_accept, w_finish, w_busy;
   logic        w_unused_ctl;

   // 18-bit signed probes keep px-1 / py-1 at zero negative and px+W near 65535 from wrapping.
   function automatic logic [4:0] box_flags(input logic [63:0] d, input logic plat,
                                            input logic [15:0] px, input logic [15:0] py,
                                            input logic drop);
      logic signed [17:0] x0, x1, y0, y1, sx, sy, xl, xr, yd, yu;
      logic               ok, xov, yov;
      x0  = $signed({2'b00, d[63:48]});
      x1  = $signed({2'b00, d[47:32]});
      y0  = $signed({2'b00, d[31:16]});
      y1  = $signed({2'b00, d[15:0]});
      sx  = $signed({2'b00, px});
      sy  = $signed({2'b00, py});
      xl  = sx - 18'sd1;
      xr  = sx + LP_W;
      yd  = sy - 18'sd1;
      yu  = sy + LP_H;
      ok  = (x0 <= x1) && (y0 <= y1);
      xov = (sx <= x1) && ((xr - 18'sd1) >= x0);
      yov = (sy <= y1) && ((yu - 18'sd1) >= y0);
      box_flags = '0;
      if (ok) begin
         if (plat) begin
            box_flags[4] = xov && (yd == y1) && !drop;
         end else begin
            box_flags[0] = xov && (yu >= y0) && (yu <= y1);
            box_flags[1] = xov && (yd >= y0) && (yd <= y1);
            box_flags[2] = yov && (xr >= x0) && (xr <= x1);
            box_flags[3] = yov && (xl >= x0) && (xl <= x1);
         end
      end
   endfunction

   assign w_cur        = box_flags(bus.box_data, bus.box_is_platform, r_px, r_py, r_drop);
   assign w_last       = (r_addr == LP_LAST);
   assign w_unused_ctl = ^{i_controller_in[31:8], i_controller_in[3:0]};

   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_next_state = S_SCAN;
         S_SCAN:  if (w_last)  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_busy   = (r_state == S_SCAN);
      w_accept = (r_state == S_IDLE) && i_start;
      w_finish = (r_state == S_SCAN) && w_last;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_addr <= '0;
         r_rd   <= 1'b0;
         r_done <= 1'b0;
         r_wall <= '0;
      end else begin
         r_done <= w_finish;
         if (w_accept) begin
            r_addr <= '0;
            r_rd   <= 1'b1;
         end else if (w_busy) begin
            if (w_last) r_rd   <= 1'b0;
            else        r_addr <= r_addr + 8'd1;
         end
         if (w_finish) r_wall <= r_acc | w_cur;
      end
   end

   // Scan snapshot and accumulator carry no reset; they are rewritten on every accepted start.
   always_ff @(posedge i_clock) begin
      if (w_accept) begin
         r_px   <= i_position[31:16];
         r_py   <= i_position[15:0];
         r_drop <= (i_controller_in[7:4] == 4'd0);
         r_acc  <= '0;
      end else if (w_busy) begin
         r_acc  <= r_acc | w_cur;
      end
   end

   assign bus.box_addr = r_addr;
   assign bus.box_rd   = r_rd;
   assign o_wall       = {27'd0, r_wall};
   assign o_busy       = w_busy;
   assign o_done       = r_done;

endmodule

// File: tb/tb_stage_collision.sv
// Bench for stage_collision: directed scenarios plus random boxes checked against a behavioural model.
module tb_stage_collision;
   localparam int NB = 4;
   localparam int PW = 16;
   localparam int PH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] position = '0;
   logic [31:0] ctl = '0;
   logic [31:0] wall;
   logic        busy, done;
   int          n_chk = 0;
   int          n_fail = 0;

   logic [15:0] rx0 [256];
   logic [15:0] rx1 [256];
   logic [15:0] ry0 [256];
   logic [15:0] ry1 [256];
   logic        rpl [256];

   stage_collision_if bus();

   assign bus.box_data        = {rx0[bus.box_addr], rx1[bus.box_addr], ry0[bus.box_addr], ry1[bus.box_addr]};
   assign bus.box_is_platform = rpl[bus.box_addr];

   stage_collision #(.NUM_BOXES(NB), .PLAYER_W(PW), .PLAYER_H(PH)) dut (
      .i_clock         (clk),
      .i_reset         (rst),
      .i_start         (start),
      .i_position      (position),
      .i_controller_in (ctl),
      .bus             (bus),
      .o_wall          (wall),
      .o_busy          (busy),
      .o_done          (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected end of test");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_box(input int i, input int x0, input int x1, input int y0, input int y1, input bit pl);
      rx0[i] = x0[15:0];
      rx1[i] = x1[15:0];
      ry0[i] = y0[15:0];
      ry1[i] = y1[15:0];
      rpl[i] = pl;
   endtask

   task automatic clear_boxes();
      for (int i = 0; i < 256; i++) set_box(i, 1, 0, 1, 0, 1'b0);
   endtask

   // Contact rules restated with plain integer arithmetic over the box table.
   function automatic logic [31:0] model(input int px, input int py, input logic [31:0] c);
      logic [31:0] r;
      bit drop, xo, yo;
      int x0, x1, y0, y1;
      r = '0;
      drop = (c[7:4] == 4'd0);
      for (int i = 0; i < NB; i++) begin
         x0 = int'(rx0[i]); x1 = int'(rx1[i]);
         y0 = int'(ry0[i]); y1 = int'(ry1[i]);
         if (x0 > x1 || y0 > y1) continue;
         xo = (px <= x1) && (px + PW - 1 >= x0);
         yo = (py <= y1) && (py + PH - 1 >= y0);
         if (rpl[i]) begin
            if (xo && (py - 1 == y1) && !drop) r[4] = 1'b1;
         end else begin
            if (xo && (py - 1 >= y0) && (py - 1 <= y1)) r[1] = 1'b1;
            if (xo && (py + PH >= y0) && (py + PH <= y1)) r[0] = 1'b1;
            if (yo && (px - 1 >= x0) && (px - 1 <= x1)) r[3] = 1'b1;
            if (yo && (px + PW >= x0) && (px + PW <= x1)) r[2] = 1'b1;
         end
      end
      return r;
   endfunction

   task automatic begin_scan(input int px, input int py, input logic [31:0] c);
      @(negedge clk);
      position = {px[15:0], py[15:0]};
      ctl      = c;
      start    = 1'b1;
   endtask

   // inject: 0 none, 1 extra start sampled at E2, 2 position scrambled mid-scan.
   task automatic finish_scan(input string tag, input logic [31:0] exp, input int inject,
                              input bit chain, input int cpx, input int cpy, input logic [31:0] cctl);
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, " busy@E0"}, 32'(busy), 32'd1);
      check({tag, " rd@E0"}, 32'(bus.box_rd), 32'd1);
      check({tag, " addr@E0"}, 32'(bus.box_addr), 32'd0);
      for (int k = 1; k < NB; k++) begin
         @(posedge clk); #1;
         check({tag, " addr"}, 32'(bus.box_addr), k);
         check({tag, " rd"}, 32'(bus.box_rd), 32'd1);
         check({tag, " done early"}, 32'(done), 32'd0);
         if (k == 1 && inject == 1) start = 1'b1;
         if (k == 2 && inject == 1) start = 1'b0;
         if (k == 1 && inject == 2) begin
            position = $urandom;
            ctl      = $urandom;
         end
      end
      @(posedge clk); #1;
      check({tag, " done"}, 32'(done), 32'd1);
      check({tag, " busy end"}, 32'(busy), 32'd0);
      check({tag, " wall"}, wall, exp);
      check({tag, " rd end"}, 32'(bus.box_rd), 32'd0);
      if (chain) begin
         position = {cpx[15:0], cpy[15:0]};
         ctl      = cctl;
         start    = 1'b1;
      end else begin
         @(posedge clk); #1;
         check({tag, " done width"}, 32'(done), 32'd0);
         check({tag, " idle after"}, 32'(busy), 32'd0);
         check({tag, " wall hold"}, wall, exp);
      end
   endtask

   initial begin
      logic [31:0] exp;
      int px, py, x0, y0;
      clear_boxes();
      rst = 1'b1;
      start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst wall", wall, 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst rd", 32'(bus.box_rd), 32'd0);
      check("rst addr", 32'(bus.box_addr), 32'd0);
      rst = 1'b0;
      start = 1'b0;

      set_box(0, 0, 639, 0, 31, 1'b0);
      begin_scan(100, 32, 32'h0);  finish_scan("floor", 32'h2, 0, 1'b0, 0, 0, 0);
      begin_scan(100, 40, 32'h0);  finish_scan("above floor", 32'h0, 0, 1'b0, 0, 0, 0);

      clear_boxes();
      set_box(0, 200, 299, 100, 103, 1'b1);
      begin_scan(250, 104, 32'h80); finish_scan("platform", 32'h10, 0, 1'b0, 0, 0, 0);
      begin_scan(250, 104, 32'h05); finish_scan("platform drop", 32'h0, 0, 1'b0, 0, 0, 0);
      begin_scan(250, 103, 32'h80); finish_scan("platform inside", 32'h0, 0, 1'b0, 0, 0, 0);

      clear_boxes();
      set_box(0, 400, 419, 0, 479, 1'b0);
      begin_scan(384, 200, 32'h0); finish_scan("pillar right", 32'h4, 0, 1'b0, 0, 0, 0);
      begin_scan(420, 200, 32'h0); finish_scan("pillar left", 32'h8, 0, 1'b0, 0, 0, 0);
      clear_boxes();
      set_box(0, 0, 639, 216, 230, 1'b0);
      begin_scan(100, 200, 32'h0); finish_scan("ceiling", 32'h1, 0, 1'b0, 0, 0, 0);

      clear_boxes();
      set_box(0, 65530, 65535, 0, 100, 1'b0);
      set_box(1, 0, 100, 65530, 65535, 1'b0);
      begin_scan(0, 0, 32'h0);     finish_scan("origin no wrap", 32'h0, 0, 1'b0, 0, 0, 0);
      clear_boxes();
      set_box(0, 0, 10, 0, 479, 1'b0);
      begin_scan(65530, 100, 32'h0); finish_scan("right edge no wrap", 32'h0, 0, 1'b0, 0, 0, 0);
      clear_boxes();
      set_box(0, 50, 40, 0, 10, 1'b0);
      begin_scan(40, 11, 32'h0);   finish_scan("inverted box", 32'h0, 0, 1'b0, 0, 0, 0);

      clear_boxes();
      set_box(2, 0, 639, 0, 31, 1'b0);
      begin_scan(100, 32, 32'h0);  finish_scan("start while busy", 32'h2, 1, 1'b0, 0, 0, 0);
      begin_scan(100, 32, 32'h0);  finish_scan("snapshot", 32'h2, 2, 1'b0, 0, 0, 0);
      begin_scan(100, 40, 32'h0);  finish_scan("b2b first", 32'h0, 0, 1'b1, 100, 32, 32'h0);
      finish_scan("b2b second", 32'h2, 0, 1'b0, 0, 0, 0);

      begin_scan(100, 40, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      start = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst wall", wall, 32'd0);
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst done", 32'(done), 32'd0);
      check("midrst rd", 32'(bus.box_rd), 32'd0);
      for (int k = 0; k < NB + 2; k++) begin
         @(posedge clk); #1;
         check("midrst no done", 32'(done), 32'd0);
      end
      begin_scan(100, 32, 32'h0);  finish_scan("after reset", 32'h2, 0, 1'b0, 0, 0, 0);

      for (int it = 0; it < 40; it++) begin
         clear_boxes();
         for (int i = 0; i < NB; i++) begin
            x0 = $urandom_range(0, 127);
            y0 = $urandom_range(0, 127);
            if ($urandom % 8 == 0)
               set_box(i, x0 + 1, x0, y0, y0 + $urandom_range(0, 60), 1'b0);
            else
               set_box(i, x0, x0 + $urandom_range(0, 60), y0, y0 + $urandom_range(0, 60), ($urandom % 3) == 0);
         end
         px = $urandom_range(0, 180);
         py = $urandom_range(0, 180);
         ctl = $urandom;
         if ($urandom % 2 == 1) ctl[7:4] = 4'd0;
         if (it % 4 == 0) begin
            rpl[0] = 1'b1;
            py = int'(ry1[0]) + 1;
            px = int'(rx0[0]);
            ctl[7:4] = 4'h8;
         end
         exp = model(px, py, ctl);
         begin_scan(px, py, ctl);
         finish_scan("random", exp, 0, 1'b0, 0, 0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
